// File: rtl/spi_master_tx_if.sv
// Parallel and serial signal bundle for the SPI transmit master.
//   master modport : the spi_master_tx side (drives busy/done/rx_data and the serial pins)
//   slave modport  : the controller/board side (drives start/tx_data and the miso return)
// Parallel side: start, tx_data, busy, done, rx_data.
// Serial side  : sclk, mosi, sel_n (to the slave), miso (from the slave).
interface spi_master_tx_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  sclk;
  logic                  mosi;
  logic                  sel_n;
  logic                  miso;

  modport master (
    input  start, tx_data, miso,
    output busy, done, rx_data, sclk, mosi, sel_n
  );

  modport slave (
    output start, tx_data, miso,
    input  busy, done, rx_data, sclk, mosi, sel_n
  );
endinterface

// File: rtl/spi_master_tx.sv
// SPI master (mode 0) that serialises one parallel word per start pulse,
// MSB first, and captures the slave's return line into rx_data.
//   clk  : system clock, all logic on its rising edge
//   rst  : synchronous, active-high reset
//   bus  : spi_master_tx_if.master
//          start/tx_data in, busy/done/rx_data out (parallel side)
//          sclk/mosi/sel_n out, miso in (serial side)
// Frame shape (CLK_DIV system clocks per sclk half-period):
//   SETUP one half-period with sel_n low and sclk low, SHIFT DATA_WIDTH
//   sclk periods (rise samples miso, fall advances mosi), HOLD one
//   half-period with sclk low, then done pulses as sel_n returns high.
module spi_master_tx #(
  parameter int DATA_WIDTH = 4,
  parameter int CLK_DIV    = 2
) (
  input logic              clk,
  input logic              rst,
  spi_master_tx_if.master  bus
);

  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  state_t                state;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic                  tick;

  logic                  busy_r;
  logic                  done_r;
  logic [DATA_WIDTH-1:0] rx_data_r;
  logic                  sclk_r;
  logic                  mosi_r;
  logic                  sel_n_r;

  // One half-period of sclk has elapsed. With CLK_DIV=1 this is every cycle.
  assign tick = (div_cnt == DIV_LAST);

  // NOTE: every register here, including the shift registers, is assigned
  // with <= so all updates in a cycle see the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      rx_data_r <= '0;
      sclk_r    <= 1'b0;
      mosi_r    <= 1'b0;
      sel_n_r   <= 1'b1;
    end else begin
      // done is a single-cycle pulse; only the HOLD exit raises it again.
      done_r <= 1'b0;

      // The divider only runs while a frame is in progress and wraps on tick.
      if (state == IDLE || tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            tx_shift <= bus.tx_data;
            bit_cnt  <= '0;
            mosi_r   <= bus.tx_data[DATA_WIDTH-1];
            sel_n_r  <= 1'b0;
            busy_r   <= 1'b1;
            state    <= SETUP;
          end
        end

        SETUP: begin
          if (tick) begin
            state <= SHIFT;
          end
        end

        SHIFT: begin
          if (tick) begin
            if (!sclk_r) begin
              // Rising tick: the slave changed miso on the previous fall,
              // so it is stable here.
              sclk_r   <= 1'b1;
              rx_shift <= {rx_shift[DATA_WIDTH-2:0], bus.miso};
            end else begin
              sclk_r <= 1'b0;
              if (bit_cnt != LAST_BIT) begin
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                mosi_r   <= tx_shift[DATA_WIDTH-2];
                bit_cnt  <= bit_cnt + 1'b1;
              end else begin
                // Last bit already sent; mosi keeps its value into HOLD.
                state <= HOLD;
              end
            end
          end
        end

        HOLD: begin
          if (tick) begin
            state     <= IDLE;
            sel_n_r   <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            rx_data_r <= rx_shift;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.rx_data = rx_data_r;
  assign bus.sclk    = sclk_r;
  assign bus.mosi    = mosi_r;
  assign bus.sel_n   = sel_n_r;

endmodule

// File: tb/tb_spi_master_tx.sv
// Self-checking bench for spi_master_tx. Two instances share one clock:
// index 0 uses CLK_DIV=2, index 1 uses CLK_DIV=1. A monitor records, per
// instance, the mosi value at every sclk rising edge, the cycles with sel_n
// low and the done cycles; directed steps then compare those records with
// values derived from the frame rules (latency formula, MSB-first order).
module tb_spi_master_tx;

  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  spi_master_tx_if #(.DATA_WIDTH(DW)) b2 ();
  spi_master_tx_if #(.DATA_WIDTH(DW)) b1 ();

  spi_master_tx #(.DATA_WIDTH(DW), .CLK_DIV(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  spi_master_tx #(.DATA_WIDTH(DW), .CLK_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // miso source for the CLK_DIV=2 instance: 0 constant, 1 loopback, 2 slave model.
  int          msrc       = 0;
  logic        const_miso = 1'b0;
  logic        slave_bit  = 1'b0;
  logic [DW-1:0] slave_word = '0;
  int          slave_idx  = -1;
  logic        prev_sel_n = 1'b1;

  assign b2.miso = (msrc == 1) ? b2.mosi : (msrc == 2) ? slave_bit : const_miso;
  assign b1.miso = b1.mosi;

  // Per-instance monitor records.
  logic rise_q    [2][$];
  int   sel_low_q [2][$];
  int   done_q    [2][$];
  int   mosi_hi   [2];
  logic prev_sclk [2];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input int d, input logic sclk, input logic mosi,
                        input logic sel_n, input logic done);
    if (sclk && !prev_sclk[d]) rise_q[d].push_back(mosi);
    if (!sel_n) begin
      sel_low_q[d].push_back(cyc);
      if (mosi) mosi_hi[d]++;
    end
    if (done) done_q[d].push_back(cyc);
    prev_sclk[d] = sclk;
  endtask

  // Sample 2 time units after each rising edge, i.e. the settled outputs of cycle 'cyc'.
  initial begin
    prev_sclk[0] = 1'b0;
    prev_sclk[1] = 1'b0;
    mosi_hi[0]   = 0;
    mosi_hi[1]   = 0;
    forever begin
      @(posedge clk);
      #2;
      // Mode-0 slave: present MSB when selected, next bit after each sclk fall.
      if (prev_sel_n && !b2.sel_n) begin
        slave_bit = slave_word[DW-1];
        slave_idx = DW - 2;
      end else if (prev_sclk[0] && !b2.sclk && slave_idx >= 0) begin
        slave_bit = slave_word[slave_idx];
        slave_idx--;
      end
      prev_sel_n = b2.sel_n;
      sample(0, b2.sclk, b2.mosi, b2.sel_n, b2.done);
      sample(1, b1.sclk, b1.mosi, b1.sel_n, b1.done);
    end
  end

  task automatic clear(input int d);
    rise_q[d].delete();
    sel_low_q[d].delete();
    done_q[d].delete();
    mosi_hi[d] = 0;
  endtask

  // NOTE: stimulus is driven with blocking assignments on the falling edge,
  // half a cycle away from the edge where the DUT samples it.
  task automatic drive(input int d, input logic s, input logic [DW-1:0] tx);
    if (d == 0) begin
      b2.start   = s;
      b2.tx_data = tx;
    end else begin
      b1.start   = s;
      b1.tx_data = tx;
    end
  endtask

  function automatic logic [31:0] rises_word(input int d);
    logic [31:0] w = '0;
    for (int i = 0; i < rise_q[d].size(); i++) w = {w[30:0], rise_q[d][i]};
    return w;
  endfunction

  function automatic logic [DW-1:0] rx_of(input int d);
    return (d == 0) ? b2.rx_data : b1.rx_data;
  endfunction

  function automatic logic busy_of(input int d);
    return (d == 0) ? b2.busy : b1.busy;
  endfunction

  // One frame from the idle state; tx_data is scrambled every cycle after
  // acceptance. With reject=1 a second start (4'b0011) arrives at T+5.
  task automatic run_frame(input string tag, input int d, input logic [DW-1:0] tx,
                           input logic [DW-1:0] exp_rx, input bit reject);
    int t;
    int div;
    int lat;
    div = (d == 0) ? 2 : 1;
    lat = 1 + div * (2 * DW + 2);
    clear(d);
    @(negedge clk);
    drive(d, 1'b1, tx);
    t = cyc;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (reject && cyc == t + 5) drive(d, 1'b1, 4'b0011);
      else drive(d, 1'b0, DW'($urandom));
    end
    check({tag, "_done_count"}, done_q[d].size(), 1);
    if (done_q[d].size() > 0) check({tag, "_done_cycle"}, done_q[d][0], t + lat);
    check({tag, "_sclk_rises"}, rise_q[d].size(), DW);
    check({tag, "_mosi_bits"}, rises_word(d), {28'd0, tx});
    check({tag, "_rx_data"}, rx_of(d), exp_rx);
    check({tag, "_sel_low_len"}, sel_low_q[d].size(), lat - 1);
    if (sel_low_q[d].size() > 0) check({tag, "_sel_low_first"}, sel_low_q[d][0], t + 1);
    check({tag, "_busy_after"}, busy_of(d), 1'b0);
  endtask

  initial begin
    int t;
    bit got;
    logic [DW-1:0] a;
    logic [DW-1:0] b;

    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);

    // Power-on reset held for 3 cycles.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_sclk", b2.sclk, 1'b0);
    check("rst_mosi", b2.mosi, 1'b0);
    check("rst_sel_n", b2.sel_n, 1'b1);
    check("rst_busy", b2.busy, 1'b0);
    check("rst_done", b2.done, 1'b0);
    check("rst_rx_data", b2.rx_data, 4'b0000);
    check("rst_sel_n_d1", b1.sel_n, 1'b1);

    // Loopback 1011.
    msrc = 1;
    run_frame("loop1011", 0, 4'b1011, 4'b1011, 1'b0);

    // Idle reset afterwards: rx_data and the held mosi must clear.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_rst_rx_data", b2.rx_data, 4'b0000);
    check("idle_rst_mosi", b2.mosi, 1'b0);
    check("idle_rst_sel_n", b2.sel_n, 1'b1);

    // Constant miso with an all-zero word.
    msrc = 0;
    const_miso = 1'b1;
    run_frame("miso1", 0, 4'b0000, 4'b1111, 1'b0);
    check("miso1_mosi_high_cycles", mosi_hi[0], 0);
    const_miso = 1'b0;
    run_frame("miso0", 0, 4'b0000, 4'b0000, 1'b0);

    // Random words against a mode-0 slave returning its own random word.
    msrc = 2;
    for (int i = 0; i < 6; i++) begin
      a = DW'($urandom);
      slave_word = DW'($urandom);
      run_frame("rand_slave", 0, a, slave_word, 1'b0);
    end

    // start while busy is ignored.
    msrc = 1;
    run_frame("busy_reject", 0, 4'b1100, 4'b1100, 1'b1);

    // Reset in the middle of a frame.
    clear(0);
    @(negedge clk);
    drive(0, 1'b1, 4'b0110);
    t = cyc;
    @(negedge clk);
    drive(0, 1'b0, 4'b0000);
    while (cyc < t + 9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cycle", cyc, t + 10);
    check("midrst_sel_n", b2.sel_n, 1'b1);
    check("midrst_sclk", b2.sclk, 1'b0);
    check("midrst_busy", b2.busy, 1'b0);
    check("midrst_rx_data", b2.rx_data, 4'b0000);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("midrst_no_done", done_q[0].size(), 0);
    check("midrst_rx_after", b2.rx_data, 4'b0000);

    // Back-to-back: second start in the done cycle.
    a = DW'($urandom);
    b = DW'($urandom);
    clear(0);
    @(negedge clk);
    drive(0, 1'b1, a);
    t = cyc;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (b2.done) begin
        drive(0, 1'b1, b);
        got = 1'b1;
      end else begin
        drive(0, 1'b0, DW'($urandom));
      end
    end
    check("b2b_first_done_seen", got, 1'b1);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      drive(0, 1'b0, DW'($urandom));
    end
    check("b2b_done_count", done_q[0].size(), 2);
    if (done_q[0].size() == 2) begin
      check("b2b_done0", done_q[0][0], t + 21);
      check("b2b_done1", done_q[0][1], t + 42);
    end
    check("b2b_sel_low_len", sel_low_q[0].size(), 40);
    if (sel_low_q[0].size() == 40) begin
      check("b2b_gap_before", sel_low_q[0][19], t + 20);
      check("b2b_gap_after", sel_low_q[0][20], t + 22);
    end
    check("b2b_mosi_bits", rises_word(0), {24'd0, a, b});
    check("b2b_rx_data", b2.rx_data, b);

    // CLK_DIV=1 instance.
    run_frame("div1_1001", 1, 4'b1001, 4'b1001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      a = DW'($urandom);
      run_frame("div1_rand", 1, a, a, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
